// File: rtl/nal_unit_packer_if.sv
// Handshake and data bundle between NAL assembly and the Annex-B byte-stream packer.
// master: unit source and byte sink; slave: the packer itself.
interface nal_unit_packer_if #(
  parameter int unsigned MAX_BYTES = 384,
  parameter int unsigned SIZE_W    = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             nal_type;
  logic [8*MAX_BYTES-1:0] nal_unit;
  logic [SIZE_W-1:0]      nal_unit_size;
  logic [7:0]             out_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_start;
  logic                   out_end;
  logic [SIZE_W-1:0]      ep_count;
  logic                   busy;

  modport master (
    output in_valid, nal_type, nal_unit, nal_unit_size, out_ready,
    input  in_ready, out_byte, out_valid, out_start, out_end, ep_count, busy
  );

  modport slave (
    input  in_valid, nal_type, nal_unit, nal_unit_size, out_ready,
    output in_ready, out_byte, out_valid, out_start, out_end, ep_count, busy
  );
endinterface

// File: rtl/nal_unit_packer.sv
// Serialises one NAL unit as Annex-B: start code, header, payload, one byte per handshake.
// Define NAL_EMULATION_PREVENTION_EN to enable 0x03 emulation-prevention insertion.
module nal_unit_packer #(
  parameter int unsigned MAX_BYTES = 384,
  parameter int unsigned SIZE_W    = 10
) (
  input logic              clk,
  input logic              reset_n,
  nal_unit_packer_if.slave bus
);

`ifdef NAL_EMULATION_PREVENTION_EN
  localparam bit EpEn = 1'b1;
`else
  localparam bit EpEn = 1'b0;
`endif

  localparam int unsigned       IdxW    = $clog2(MAX_BYTES);
  localparam logic [SIZE_W-1:0] MaxSize = SIZE_W'(MAX_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StSc, StHdr, StPay, StTail} state_e;

  state_e            state_q;
  logic [1:0]        sc_idx_q;
  logic [SIZE_W-1:0] pos_q;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] ep_q;
  logic [1:0]        zrun_q;
  logic              ins_q;
  logic [7:0]        byte_q;
  logic              valid_q;
  logic              start_q;
  logic              end_q;
  logic [7:0]        type_q;
  logic [7:0]        buf_q [MAX_BYTES];

  logic              accept;
  logic              handshake;
  logic              load_body;
  logic [SIZE_W-1:0] nxt_pos;
  logic [IdxW-1:0]   pay_idx;
  logic [7:0]        nxt_b;
  logic              nxt_ins;
  logic              nxt_last;
  logic [1:0]        nxt_zrun;
  logic [SIZE_W-1:0] eff_size;

  assign accept    = (state_q == StIdle) && bus.in_valid;
  assign handshake = valid_q && bus.out_ready;
  assign eff_size  = (bus.nal_unit_size > MaxSize) ? MaxSize : bus.nal_unit_size;

  // Body position 0 is the header byte, position k is payload byte k-1.
  // pos_q names the body byte on the wire, or the one held back behind an inserted 0x03.
  always_comb begin
    load_body = 1'b0;
    nxt_pos   = pos_q + SIZE_W'(1);
    if (state_q == StSc) begin
      nxt_pos   = '0;
      load_body = handshake && (sc_idx_q == 2'd3);
    end else if (state_q == StHdr || state_q == StPay) begin
      if (ins_q) nxt_pos = pos_q;
      load_body = handshake && !end_q && (ins_q || pos_q != size_q);
    end
    pay_idx  = (nxt_pos == '0) ? '0 : IdxW'(nxt_pos - SIZE_W'(1));
    nxt_b    = (nxt_pos == '0) ? type_q : buf_q[pay_idx];
    nxt_ins  = EpEn && !ins_q && (zrun_q == 2'd2) && (nxt_b <= 8'h03);
    nxt_last = (nxt_pos == size_q);
    nxt_zrun = (nxt_b != 8'h00) ? 2'd0 : ((zrun_q == 2'd2) ? 2'd2 : zrun_q + 2'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      sc_idx_q <= '0;
      pos_q    <= '0;
      size_q   <= '0;
      ep_q     <= '0;
      zrun_q   <= '0;
      ins_q    <= 1'b0;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_q  <= StSc;
            sc_idx_q <= '0;
            size_q   <= eff_size;
            ep_q     <= '0;
            zrun_q   <= '0;
            ins_q    <= 1'b0;
            byte_q   <= 8'h00;
            valid_q  <= 1'b1;
            start_q  <= 1'b1;
            end_q    <= 1'b0;
          end
        end
        StSc: begin
          if (handshake && sc_idx_q != 2'd3) begin
            sc_idx_q <= sc_idx_q + 2'd1;
            byte_q   <= (sc_idx_q == 2'd2) ? 8'h01 : 8'h00;
            start_q  <= 1'b0;
          end
        end
        StHdr, StPay: begin
          if (handshake && end_q) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
          end else if (handshake && !ins_q && pos_q == size_q) begin
            // Last body byte was 0x00: close the unit with a trailing 0x03.
            state_q <= StTail;
            byte_q  <= 8'h03;
            end_q   <= 1'b1;
            zrun_q  <= '0;
            ep_q    <= ep_q + SIZE_W'(1);
          end
        end
        StTail: begin
          if (handshake) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase

      if (load_body) begin
        state_q <= (nxt_pos == '0) ? StHdr : StPay;
        pos_q   <= nxt_pos;
        start_q <= 1'b0;
        if (nxt_ins) begin
          byte_q <= 8'h03;
          ins_q  <= 1'b1;
          zrun_q <= '0;
          end_q  <= 1'b0;
          ep_q   <= ep_q + SIZE_W'(1);
        end else begin
          byte_q <= nxt_b;
          ins_q  <= 1'b0;
          zrun_q <= nxt_zrun;
          end_q  <= nxt_last && !(EpEn && nxt_b == 8'h00);
        end
      end
    end
  end

  // Unit storage is only written on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      type_q <= bus.nal_type;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
        buf_q[i] <= bus.nal_unit[i*8 +: 8];
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_byte  = byte_q;
  assign bus.out_valid = valid_q;
  assign bus.out_start = start_q;
  assign bus.out_end   = end_q;
  assign bus.ep_count  = ep_q;

endmodule

// File: doc/nal_unit_packer.md
# nal_unit_packer

Transmit-side counterpart of the camera path's NAL unit extraction: accepts one complete NAL unit (header byte plus payload buffer) and serialises it as an Annex-B byte stream. The block prepends a 4-byte start code, inserts emulation-prevention bytes and streams one byte per cycle under valid/ready backpressure. It sits between the NAL assembly logic and the byte-stream output or loopback interface of the codec subsystem.

## Interface
- MAX_BYTES, 384: buffer capacity in bytes; header plus payload never exceeds this.
- SIZE_W, 10: width of size and count fields.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a NAL unit is presented.
- in_ready  out  1  block can accept a unit; high only in IDLE.
- nal_type  in  8  NAL header byte, emitted first after the start code.
- nal_unit  in  8*MAX_BYTES  payload; payload byte i is at [i*8 +: 8].
- nal_unit_size  in  SIZE_W  payload byte count, excluding the header byte.
- out_byte  out  8  stream byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  sink accepts out_byte.
- out_start  out  1  qualifies the first start-code byte.
- out_end  out  1  qualifies the last byte of the unit.
- ep_count  out  SIZE_W  number of 0x03 bytes inserted into the last or current unit.
- busy  out  1  a unit is being emitted.

## Operation
- Accept happens on a cycle with in_valid && in_ready. On accept, the block latches nal_type, nal_unit and the effective size.
- Effective size is min(nal_unit_size, MAX_BYTES-1).
- On accept, ep_count clears to 0 and the zero-run counter clears to 0.
- States and transitions:
  - IDLE: in_ready=1, busy=0; goes to SC on accept.
  - SC: emits 00 00 00 01; goes to HDR.
  - HDR: emits nal_type; goes to PAY, or to TAIL/IDLE when size is 0.
  - PAY: emits payload bytes 0..size-1.
  - TAIL: emits a trailing 0x03 when needed; goes to IDLE.
- Emulation prevention covers the header and payload bytes only, never the start code:
  - When zero_run==2 and the next byte is <=0x03, the block emits 0x03 first, increments ep_count and resets zero_run to 0. The pending byte is emitted on the following beat.
  - zero_run increments on each emitted 0x00 (saturating at 2) and clears on any non-zero byte.
  - If the final body byte emitted is 0x00, TAIL appends 0x03, which becomes the out_end byte and increments ep_count.
- Advancement:
  - Every state advances only on an output handshake (out_valid && out_ready).
  - out_byte, out_start and out_end hold stable while out_valid && !out_ready.
- The input buffer is not re-sampled while busy; changes on nal_* during emission are ignored.
- Reset values: in_ready=1, out_valid=0, out_byte=0x00, out_start=0, out_end=0, ep_count=0, busy=0, state IDLE.
- Reset asserted mid-unit aborts the unit immediately (asynchronous). Nothing resumes after release.

## Timing
- Accept at edge N makes out_valid=1 with out_byte=0x00 and out_start=1 from edge N, i.e. visible in cycle N+1.
- Throughput is one byte per cycle while out_ready=1, with no bubbles, including across inserted 0x03 bytes.
- Stream length is 5 + size + ep_count beats.
- The out_end handshake at edge M sets in_ready=1 and out_valid=0 from edge M. The next accept is possible at edge M+1.
- Back-to-back units therefore have exactly one idle output cycle between them.
- out_start and out_end are never both high. out_end is high on exactly one beat per unit.

## Configuration
- NAL_EMULATION_PREVENTION_EN:
  - Defined: 0x03 insertion and the TAIL rule as described.
  - Undefined: body bytes pass through raw, TAIL is never entered, ep_count stays 0, and stream length is exactly 5 + size.

## Test plan
- nal_type=0x67, size=3, payload AA BB CC, out_ready=1 -> 00 00 00 01 67 AA BB CC in 8 consecutive beats; out_start on beat 1, out_end on CC, ep_count=0.
- Payload 00 00 01 02, type 0x41 -> 00 00 00 01 41 00 00 03 01 02; ep_count=1. With the macro undefined -> no 03, 9 beats.
- Payload 00 00, type 0x06 -> 00 00 00 01 06 00 00 03, with out_end on the trailing 03; ep_count=1.
- Payload 00 00 00 00 00 00 -> body 00 00 03 00 00 03 00 00 03 plus nothing further; ep_count=3.
- Random out_ready toggling on unit 1 -> byte sequence identical to the no-stall run, and out_byte stable during every stall.
- size=0 -> 5 beats, out_end on the header.
- size=500 -> clamped to 383 payload beats.
- Reset pulsed during PAY -> out_valid=0 immediately and in_ready=1 after release; a new unit then emits cleanly from 00 00 00 01.
